// File: rtl/rv32_mem_bus.sv
// rv32 MEM stage over an external valid/ready word bus: stalls the pipeline while a
// load/store is outstanding, reports misaligned, illegal-width or timed-out accesses as faults.
module rv32_mem_bus #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic                  read_en_in,
    input  logic                  write_en_in,
    input  logic [1:0]            width_in,
    input  logic                  zero_extend_in,
    input  logic [4:0]            rd_in,
    input  logic                  rd_writeback_in,
    input  logic [ADDR_WIDTH-1:0] result_in,
    input  logic [31:0]           rs2_value_in,
    output logic                  stall_out,
    output logic                  fault_out,
    output logic [ADDR_WIDTH-1:0] fault_addr_out,
    output logic [4:0]            rd_out,
    output logic                  rd_writeback_out,
    output logic [31:0]           rd_value_out,
    output logic                  mem_valid_out,
    output logic                  mem_write_out,
    output logic [ADDR_WIDTH-3:0] mem_addr_out,
    output logic [3:0]            mem_wmask_out,
    output logic [31:0]           mem_wdata_out,
    input  logic                  mem_ready_in,
    input  logic [31:0]           mem_rdata_in
);

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;

    localparam bit TIMEOUT_EN = (TIMEOUT != 0);
    localparam int CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  mem_valid_q, mem_valid_d;
    logic                  mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-3:0] mem_addr_q, mem_addr_d;
    logic [3:0]            mem_wmask_q, mem_wmask_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  fault_q, fault_d;
    logic [ADDR_WIDTH-1:0] fault_addr_q, fault_addr_d;
    logic [4:0]            rd_q, rd_d;
    logic                  rd_wb_q, rd_wb_d;
    logic [31:0]           rd_value_q, rd_value_d;

    logic [1:0]  offset;
    logic        is_mem_req;
    logic        legal_width;
    logic        aligned;
    logic        mem_op;
    logic        bad_access;
    logic        timeout_hit;
    logic [3:0]  st_mask;
    logic [31:0] st_data;
    logic [31:0] ld_data;
    logic [31:0] result_word;

    assign offset      = result_in[1:0];
    assign result_word = 32'(result_in);
    assign is_mem_req  = valid_in && (read_en_in || write_en_in);
    assign legal_width = (width_in == WIDTH_BYTE) || (width_in == WIDTH_HALF)
                      || (width_in == WIDTH_WORD);
    assign mem_op      = is_mem_req && legal_width && aligned;
    assign bad_access  = is_mem_req && !(legal_width && aligned);
    assign timeout_hit = TIMEOUT_EN && (state_q == BUSY) && !mem_ready_in
                      && (cnt_q == CNT_LAST);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        aligned = 1'b0;
        case (width_in)
            WIDTH_BYTE: aligned = 1'b1;
            WIDTH_HALF: aligned = !offset[0];
            WIDTH_WORD: aligned = (offset == 2'b00);
            default:    aligned = 1'b0;
        endcase
    end

    // Big-endian lanes: byte offset 0 is [31:24]; unselected lanes are driven to zero.
    always_comb begin
        st_mask = 4'b0000;
        st_data = 32'h0;
        case (width_in)
            WIDTH_BYTE: begin
                case (offset)
                    2'd0: begin st_mask = 4'b1000; st_data = {rs2_value_in[7:0], 24'h0}; end
                    2'd1: begin st_mask = 4'b0100; st_data = {8'h0, rs2_value_in[7:0], 16'h0}; end
                    2'd2: begin st_mask = 4'b0010; st_data = {16'h0, rs2_value_in[7:0], 8'h0}; end
                    default: begin st_mask = 4'b0001; st_data = {24'h0, rs2_value_in[7:0]}; end
                endcase
            end
            WIDTH_HALF: begin
                if (offset[1]) begin
                    st_mask = 4'b0011;
                    st_data = {16'h0, rs2_value_in[15:0]};
                end else begin
                    st_mask = 4'b1100;
                    st_data = {rs2_value_in[15:0], 16'h0};
                end
            end
            WIDTH_WORD: begin
                st_mask = 4'b1111;
                st_data = rs2_value_in;
            end
            default: ;
        endcase
    end

    // The pipeline holds its inputs during the transaction, so the live offset and width still apply.
    always_comb begin
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        lane_b  = 8'h0;
        lane_h  = 16'h0;
        ld_data = mem_rdata_in;
        case (offset)
            2'd0:    lane_b = mem_rdata_in[31:24];
            2'd1:    lane_b = mem_rdata_in[23:16];
            2'd2:    lane_b = mem_rdata_in[15:8];
            default: lane_b = mem_rdata_in[7:0];
        endcase
        lane_h = offset[1] ? mem_rdata_in[15:0] : mem_rdata_in[31:16];
        case (width_in)
            WIDTH_BYTE: ld_data = zero_extend_in ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            WIDTH_HALF: ld_data = zero_extend_in ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default:    ld_data = mem_rdata_in;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mem_op) state_d = BUSY;
            BUSY:    if (mem_ready_in || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        mem_valid_d  = mem_valid_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wmask_d  = mem_wmask_q;
        mem_wdata_d  = mem_wdata_q;
        fault_d      = 1'b0;
        fault_addr_d = fault_addr_q;
        rd_d         = rd_q;
        rd_wb_d      = rd_wb_q;
        rd_value_d   = rd_value_q;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    mem_valid_d = 1'b1;
                    mem_write_d = write_en_in;
                    mem_addr_d  = result_in[ADDR_WIDTH-1:2];
                    mem_wmask_d = write_en_in ? st_mask : 4'b0000;
                    mem_wdata_d = write_en_in ? st_data : 32'h0;
                    cnt_d       = '0;
                    rd_wb_d     = 1'b0;
                end else begin
                    rd_d       = rd_in;
                    rd_value_d = result_word;
                    rd_wb_d    = valid_in && rd_writeback_in && !bad_access;
                    if (bad_access) begin
                        fault_d      = 1'b1;
                        fault_addr_d = result_in;
                    end
                end
            end
            BUSY: begin
                if (mem_ready_in) begin
                    mem_valid_d = 1'b0;
                    rd_d        = rd_in;
                    rd_wb_d     = rd_writeback_in;
                    rd_value_d  = mem_write_q ? result_word : ld_data;
                end else if (timeout_hit) begin
                    mem_valid_d  = 1'b0;
                    fault_d      = 1'b1;
                    fault_addr_d = result_in;
                    rd_wb_d      = 1'b0;
                end else begin
                    if (TIMEOUT_EN) cnt_d = cnt_q + 1'b1;
                    rd_wb_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            mem_valid_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wmask_q  <= 4'b0000;
            mem_wdata_q  <= 32'h0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
            rd_q         <= 5'd0;
            rd_wb_q      <= 1'b0;
            rd_value_q   <= 32'h0;
        end else begin
            // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
            cnt_q        <= cnt_d;
            mem_valid_q  <= mem_valid_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wmask_q  <= mem_wmask_d;
            mem_wdata_q  <= mem_wdata_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
            rd_q         <= rd_d;
            rd_wb_q      <= rd_wb_d;
            rd_value_q   <= rd_value_d;
        end
    end

    // Gated by reset so the stall is low during reset even if a memory op is presented.
    assign stall_out = !reset && (((state_q == IDLE) && mem_op)
                    || ((state_q == BUSY) && !mem_ready_in && !timeout_hit));

    assign fault_out        = fault_q;
    assign fault_addr_out   = fault_addr_q;
    assign rd_out           = rd_q;
    assign rd_writeback_out = rd_wb_q;
    assign rd_value_out     = rd_value_q;
    assign mem_valid_out    = mem_valid_q;
    assign mem_write_out    = mem_write_q;
    assign mem_addr_out     = mem_addr_q;
    assign mem_wmask_out    = mem_wmask_q;
    assign mem_wdata_out    = mem_wdata_q;

endmodule
